// File: rtl/processor_pkg.sv
// Purpose: shared opcodes, instruction classes and pipeline register layouts for the MIPS-subset core.
// Latency: n/a (types and pure decode helpers only).
// Backpressure: n/a.
package processor_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Unassigned opcode 111110: decodes as NOP, used to fill squashed slots.
    localparam logic [31:0] NOP_INSTR = 32'hF800_0000;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_type;

    typedef struct packed {
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
    } ifid_t;

    typedef struct packed {
        logic        vld;
        instr_type   typ;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        wen;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } idex_t;

    typedef struct packed {
        logic        vld;
        instr_type   typ;
        logic [4:0]  dst;
        logic        wen;
        logic [31:0] alu;
        logic [31:0] b;
    } exmem_t;

    typedef struct packed {
        logic        vld;
        instr_type   typ;
        logic [4:0]  dst;
        logic        wen;
        logic [31:0] res;
    } memwb_t;

    localparam ifid_t IFID_BUBBLE = '{vld: 1'b0, ir: NOP_INSTR, npc: 32'd0};

    function automatic instr_type decode_type(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    // Which register fields an instruction class actually reads (drives load-use stalls).
    function automatic logic reads_rs(input instr_type t);
        return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD) || (t == STORE) || (t == BRANCH);
    endfunction

    function automatic logic reads_rt(input instr_type t);
        return (t == RR_ALU) || (t == STORE);
    endfunction

endpackage

// File: rtl/processor_alu.sv
// Purpose: 32-bit integer ALU for RR/RM ops; loads/stores use it for base+offset.
// Latency: combinational.
// Backpressure: none.
module processor_alu
    import processor_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    // Select the operation by opcode; unknown opcodes fall through to add.
    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            OP_SUB, OP_SUBI: o_result = i_a - i_b;
            OP_AND:          o_result = i_a & i_b;
            OP_OR:           o_result = i_a | i_b;
            OP_SLT, OP_SLTI: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            OP_MUL:          o_result = i_a * i_b;
            default:         o_result = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/pipelined_processor.sv
// Purpose: 5-stage in-order MIPS-subset core with internal register file and unified word memory.
// Latency: a result reaches Reg 4 cycles after its fetch; branches resolve in EX (2-slot squash).
// Backpressure: none external; load-use hazards stall IF/ID one cycle, HLT freezes the core until rst.
module pipelined_processor
    import processor_pkg::*;
#(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        r_fetch_stop;

    ifid_t  r_ifid;
    idex_t  r_idex;
    exmem_t r_exmem;
    memwb_t r_memwb;

    logic [31:0] w_if_ir;
    logic [5:0]  w_id_op;
    logic [4:0]  w_id_rs, w_id_rt, w_id_dst;
    logic [31:0] w_id_imm, w_id_a, w_id_b;
    instr_type   w_id_type;
    logic        w_id_wen, w_load_use, w_halt_dec;
    logic [31:0] w_ex_a, w_ex_b, w_alu_b, w_alu_res, w_br_target;
    logic        w_br_taken;
    logic        w_wb_wen, w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [31:0] w_mem_rdata;

    assign halted = HALTED;

    // Register read with write-through from the instruction currently in WB.
    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0)                              return 32'd0;
        else if (w_wb_wen && (r_memwb.dst == a))    return r_memwb.res;
        else                                        return Reg[a];
    endfunction

    // EX operand bypass: the younger EX/MEM result wins over MEM/WB, both over the ID-read value.
    // A load in EX/MEM has no data yet; the load-use stall keeps consumers away from that case.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] id_val);
        if (src == 5'd0)
            return id_val;
        else if (r_exmem.vld && r_exmem.wen && (r_exmem.dst == src) && (r_exmem.typ != LOAD))
            return r_exmem.alu;
        else if (r_memwb.vld && r_memwb.wen && (r_memwb.dst == src))
            return r_memwb.res;
        else
            return id_val;
    endfunction

    assign w_if_ir     = Mem[PC[AW-1:0]];
    assign w_wb_wen    = r_memwb.vld && r_memwb.wen;
    assign w_mem_addr  = r_exmem.alu[AW-1:0];
    assign w_mem_rdata = Mem[w_mem_addr];
    assign w_mem_we    = r_exmem.vld && (r_exmem.typ == STORE);

    // ID: field extraction, destination selection, operand read and hazard detection.
    always_comb begin
        w_id_op   = r_ifid.ir[31:26];
        w_id_rs   = r_ifid.ir[25:21];
        w_id_rt   = r_ifid.ir[20:16];
        w_id_imm  = {{16{r_ifid.ir[15]}}, r_ifid.ir[15:0]};
        w_id_type = r_ifid.vld ? decode_type(w_id_op) : NOP;
        w_id_dst  = 5'd0;
        case (w_id_type)
            RR_ALU:       w_id_dst = r_ifid.ir[15:11];
            RM_ALU, LOAD: w_id_dst = w_id_rt;
            default:      w_id_dst = 5'd0;
        endcase
        w_id_wen   = (w_id_dst != 5'd0);
        w_id_a     = rf_read(w_id_rs);
        w_id_b     = rf_read(w_id_rt);
        w_load_use = r_idex.vld && (r_idex.typ == LOAD) && (r_idex.dst != 5'd0) &&
                     ((reads_rs(w_id_type) && (w_id_rs == r_idex.dst)) ||
                      (reads_rt(w_id_type) && (w_id_rt == r_idex.dst)));
        w_halt_dec = (w_id_type == HALT) && !w_br_taken;
    end

    // EX: bypassed operands, immediate select and branch resolution.
    always_comb begin
        w_ex_a      = fwd(r_idex.rs, r_idex.a);
        w_ex_b      = fwd(r_idex.rt, r_idex.b);
        w_alu_b     = (r_idex.typ == RR_ALU) ? w_ex_b : r_idex.imm;
        w_br_target = r_idex.npc + r_idex.imm;
        w_br_taken  = r_idex.vld && (r_idex.typ == BRANCH) &&
                      (((r_idex.op == OP_BNEQZ) && (w_ex_a != 32'd0)) ||
                       ((r_idex.op == OP_BEQZ)  && (w_ex_a == 32'd0)));
    end

    processor_alu u_alu (
        .i_op     (r_idex.op),
        .i_a      (w_ex_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_res)
    );

    // Pipeline advance: squash on taken branch, stop fetch on HLT, bubble on load-use, freeze once halted.
    always_ff @(posedge clk1) begin
        if (rst) begin
            PC           <= RESET_PC;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            r_fetch_stop <= 1'b0;
            r_ifid       <= IFID_BUBBLE;
            r_idex       <= '0;
            r_exmem      <= '0;
            r_memwb      <= '0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= w_br_taken;
            HALTED       <= r_memwb.vld && (r_memwb.typ == HALT);
            r_fetch_stop <= r_fetch_stop || w_halt_dec;

            if (w_br_taken) begin
                PC     <= w_br_target;
                r_ifid <= IFID_BUBBLE;
            end else if (w_halt_dec || r_fetch_stop) begin
                r_ifid <= IFID_BUBBLE;
            end else if (!w_load_use) begin
                PC     <= PC + 32'd1;
                r_ifid <= '{vld: 1'b1, ir: w_if_ir, npc: PC + 32'd1};
            end

            if (w_br_taken || w_load_use)
                r_idex <= '0;
            else
                r_idex <= '{vld: r_ifid.vld, typ: w_id_type, op: w_id_op, rs: w_id_rs, rt: w_id_rt,
                            dst: w_id_dst, wen: w_id_wen, a: w_id_a, b: w_id_b, imm: w_id_imm,
                            npc: r_ifid.npc};

            r_exmem <= '{vld: r_idex.vld, typ: r_idex.typ, dst: r_idex.dst, wen: r_idex.wen,
                         alu: w_alu_res, b: w_ex_b};

            r_memwb <= '{vld: r_exmem.vld, typ: r_exmem.typ, dst: r_exmem.dst, wen: r_exmem.wen,
                         res: (r_exmem.typ == LOAD) ? w_mem_rdata : r_exmem.alu};
        end
    end

    // Register file write in WB; contents survive reset so preloads stay intact.
    always_ff @(posedge clk1) begin
        if (!rst && !HALTED && w_wb_wen)
            Reg[r_memwb.dst] <= r_memwb.res;
    end

    // Data-side memory write for stores in MEM; contents survive reset.
    always_ff @(posedge clk1) begin
        if (!rst && !HALTED && w_mem_we)
            Mem[w_mem_addr] <= r_exmem.b;
    end

endmodule

// File: tb/tb_pipelined_processor.sv
module tb_pipelined_processor;

    localparam logic [5:0] OPC_ADD  = 6'b000000, OPC_SUB  = 6'b000001, OPC_MUL  = 6'b000101;
    localparam logic [5:0] OPC_SLT  = 6'b000100, OPC_ADDI = 6'b001010, OPC_SUBI = 6'b001011;
    localparam logic [5:0] OPC_SW   = 6'b001001, OPC_BNEQZ = 6'b001101, OPC_BEQZ = 6'b001110;
    localparam logic [31:0] HLT_W   = 32'hFC00_0000;

    localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HALT = 3, K_PIPE = 4;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    logic halted;

    exp_t        exp_q[$];
    logic [31:0] prog[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          halt_seen = 1'b0;
    bit          snap_req = 1'b0;

    pipelined_processor dut (
        .clk1   (clk1),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] enc_rr(logic [5:0] op, int rs, int rt, int rd);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_ri(logic [5:0] op, int rs, int rt, int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.Reg[idx[4:0]];
            K_MEM:   return dut.Mem[idx[9:0]];
            K_PC:    return dut.PC;
            K_HALT:  return {31'd0, halted};
            default: return {28'd0, dut.r_ifid.vld, dut.r_idex.vld, dut.r_exmem.vld, dut.r_memwb.vld};
        endcase
    endfunction

    task automatic expect_val(input int kind, input int idx, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic check_one(input exp_t e);
        logic [31:0] act;
        act = actual(e.kind, e.idx);
        vectors++;
        if (act !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
    endtask

    // Monitor: drains the scoreboard when the core reports halt or a snapshot is requested.
    initial begin
        forever begin
            @(negedge clk1);
            if ((halted && !halt_seen) || snap_req) begin
                if (halted) halt_seen = 1'b1;
                while (exp_q.size() > 0) check_one(exp_q.pop_front());
                snap_req = 1'b0;
            end
        end
    end

    // Hold reset for two edges, then clear memory, preload Reg[k]=k and the program.
    task automatic begin_test();
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        halt_seen = 1'b0;
        for (int i = 0; i < 1024; i++) dut.Mem[i] <= 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.Mem[i] <= prog[i];
        for (int k = 0; k < 32; k++) dut.Reg[k] <= k;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halt_seen && n < budget) begin
            @(posedge clk1);
            n++;
        end
        if (!halt_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no halt within %0d cycles, expected halted=1", name, budget);
            exp_q.delete();
        end
    endtask

    task automatic snapshot(input string name);
        int n = 0;
        snap_req = 1'b1;
        while (snap_req && n < 4) begin
            @(posedge clk1);
            n++;
        end
        if (snap_req) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: snapshot not taken, got pending, expected done", name);
            snap_req = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        // Test 1: given program with OR fillers; also the reset state.
        prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                 32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        begin_test();
        expect_val(K_PC,   0, 32'd0, "rst_pc");
        expect_val(K_HALT, 0, 32'd0, "rst_halted");
        expect_val(K_PIPE, 0, 32'd0, "rst_pipe_empty");
        snapshot("rst_state");
        dut.Mem[120] <= 32'd85;
        expect_val(K_REG, 1,   32'd120, "t1_r1");
        expect_val(K_REG, 2,   32'd130, "t1_r2");
        expect_val(K_REG, 3,   32'd3,   "t1_r3");
        expect_val(K_MEM, 120, 32'd85,  "t1_mem120");
        expect_val(K_MEM, 121, 32'd130, "t1_mem121");
        expect_val(K_PC,  0,   32'd8,   "t1_pc");
        rst = 1'b0;
        wait_halt("t1_halt", 200);

        // Test 2: same program without fillers (bypass + load-use stall).
        prog = '{32'h28010078, 32'h20220000, 32'h2842002d, 32'h24220001, 32'hfc000000};
        begin_test();
        dut.Mem[120] <= 32'd85;
        expect_val(K_REG, 1,   32'd120, "t2_r1");
        expect_val(K_REG, 2,   32'd130, "t2_r2");
        expect_val(K_MEM, 120, 32'd85,  "t2_mem120");
        expect_val(K_MEM, 121, 32'd130, "t2_mem121");
        expect_val(K_PC,  0,   32'd5,   "t2_pc");
        rst = 1'b0;
        wait_halt("t2_halt", 200);

        // Test 3: back-to-back ALU ops, signed SLT, BEQZ skipping one instruction.
        prog = '{enc_ri(OPC_ADDI, 0, 1, 10), enc_ri(OPC_ADDI, 0, 2, 20),
                 enc_rr(OPC_ADD, 1, 2, 3),    enc_rr(OPC_MUL, 3, 3, 4),
                 enc_rr(OPC_SUB, 1, 2, 5),    enc_rr(OPC_SLT, 5, 1, 6),
                 enc_ri(OPC_BEQZ, 0, 0, 1),   enc_ri(OPC_ADDI, 0, 8, 55), HLT_W};
        begin_test();
        expect_val(K_REG, 3, 32'd30,        "t3_add");
        expect_val(K_REG, 4, 32'd900,       "t3_mul");
        expect_val(K_REG, 5, 32'hFFFF_FFF6, "t3_sub");
        expect_val(K_REG, 6, 32'd1,         "t3_slt");
        expect_val(K_REG, 8, 32'd8,         "t3_beqz_skip");
        expect_val(K_PC,  0, 32'd9,         "t3_pc");
        rst = 1'b0;
        wait_halt("t3_halt", 200);

        // Test 4: counted loop; the fall-through ADDI r10 must commit exactly once.
        prog = '{enc_ri(OPC_ADDI, 0, 1, 3),  enc_ri(OPC_ADDI, 0, 2, 0),
                 enc_ri(OPC_ADDI, 2, 2, 2),  enc_ri(OPC_SUBI, 1, 1, 1),
                 enc_ri(OPC_BNEQZ, 1, 0, -3), enc_ri(OPC_ADDI, 10, 10, 1), HLT_W};
        begin_test();
        expect_val(K_REG, 1,  32'd0,  "t4_r1");
        expect_val(K_REG, 2,  32'd6,  "t4_r2");
        expect_val(K_REG, 10, 32'd11, "t4_wrong_path");
        expect_val(K_PC,  0,  32'd7,  "t4_pc");
        rst = 1'b0;
        wait_halt("t4_halt", 300);

        // Test 5: instructions after HLT never commit; state stays frozen.
        prog = '{enc_ri(OPC_ADDI, 0, 1, 5), HLT_W, enc_ri(OPC_SW, 0, 1, 50), enc_ri(OPC_ADDI, 0, 3, 7)};
        begin_test();
        expect_val(K_REG, 1,  32'd5, "t5_r1");
        expect_val(K_MEM, 50, 32'd0, "t5_sw_squashed");
        expect_val(K_REG, 3,  32'd3, "t5_addi_squashed");
        expect_val(K_PC,  0,  32'd2, "t5_pc");
        rst = 1'b0;
        wait_halt("t5_halt", 200);
        repeat (10) @(posedge clk1);
        expect_val(K_HALT, 0,  32'd1, "t5_halted_stays");
        expect_val(K_PC,   0,  32'd2, "t5_pc_frozen");
        expect_val(K_REG,  3,  32'd3, "t5_r3_frozen");
        expect_val(K_MEM,  50, 32'd0, "t5_mem50_frozen");
        snapshot("t5_frozen");

        // Test 6: reset mid-run clears control state but keeps Reg/Mem.
        prog = '{enc_ri(OPC_ADDI, 0, 7, 77), enc_ri(OPC_SW, 0, 7, 60)};
        for (int i = 2; i < 30; i++) prog.push_back(32'd0);
        prog.push_back(HLT_W);
        begin_test();
        rst = 1'b0;
        repeat (12) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1);
        expect_val(K_PC,   0,  32'd0,  "t6_pc_reset");
        expect_val(K_HALT, 0,  32'd0,  "t6_halted_reset");
        expect_val(K_PIPE, 0,  32'd0,  "t6_pipe_empty");
        expect_val(K_REG,  7,  32'd77, "t6_reg_kept");
        expect_val(K_MEM,  60, 32'd77, "t6_mem_kept");
        expect_val(K_MEM,  0,  32'h2807_004D, "t6_prog_kept");
        snapshot("t6_midrun_reset");
        @(negedge clk1);
        rst = 1'b0;
        expect_val(K_REG, 7,  32'd77, "t6_rerun_r7");
        expect_val(K_MEM, 60, 32'd77, "t6_rerun_mem60");
        expect_val(K_PC,  0,  32'd31, "t6_rerun_pc");
        wait_halt("t6_halt", 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
